usb_tx: RTL and testbench



---
 rtl/usb_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/usb_tx.sv | 156 +++++++++++++++
 tb/tb_usb_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the FT245 USB FIFO port blocks: writer FSM states,
// FT245 write-cycle timing defaults and the bus byte width.
package usb_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WR_HI_DFLT    = 5;
  localparam int unsigned HOLD_DFLT     = 2;
  localparam int unsigned TXE_WAIT_DFLT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SETUP = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } usb_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; the pointers carry one
// extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [AW:0]  wr_ptr_n, rd_ptr_n;
  logic         do_wr, do_rd;

  assign do_wr    = wr_en && !full;
  assign do_rd    = rd_en && !empty;
  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_wr};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_rd};

  // Flags are computed from the next pointers so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
      empty  <= (wr_ptr_n == rd_ptr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/usb_tx.sv
// Host-bound byte transmitter for the FT245 FIFO port: buffers producer bytes
// and issues timed WR strobes. Define USB_TX_SI_EN for the idle SI flush.
module usb_tx
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WR_HI    = WR_HI_DFLT,
  parameter int unsigned HOLD     = HOLD_DFLT,
  parameter int unsigned TXE_WAIT = TXE_WAIT_DFLT,
  parameter int unsigned SI_IDLE  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              txe,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              wr,
  output logic [BYTE_W-1:0] d_out,
  output logic              d_oe,
  output logic              SI
);

  localparam int unsigned CNT_MAX = max3(WR_HI, HOLD, TXE_WAIT);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  usb_state_e        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              txe_m, txe_s;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] head;

  // TXE# is idle-high, so the synchronizer resets to "not ready".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= txe;
      txe_s <= txe_m;
    end
  end

  sync_fifo #(
    .W     (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign tx_ready = !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    pop     = 1'b0;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_n = ST_REQ;
      ST_REQ:   if (bus_gnt && !txe_s) state_n = ST_SETUP;
      ST_SETUP: begin
        if (cnt == CW'(WR_HI - 1)) state_n = ST_HOLD;
        else                       cnt_n   = cnt + CW'(1);
      end
      ST_HOLD: begin
        pop = (cnt == '0);
        if (cnt == CW'(HOLD - 1)) state_n = ST_GAP;
        else                      cnt_n   = cnt + CW'(1);
      end
      ST_GAP: begin
        if (cnt == CW'(TXE_WAIT - 1)) state_n = ST_IDLE;
        else                          cnt_n   = cnt + CW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state: glitch-free, same timing
  // as a decode of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr      <= 1'b0;
      d_oe    <= 1'b0;
      bus_req <= 1'b0;
      d_out   <= '0;
    end else begin
      wr      <= (state_n == ST_SETUP);
      d_oe    <= (state_n == ST_SETUP) || (state_n == ST_HOLD);
      bus_req <= (state_n == ST_REQ) || (state_n == ST_SETUP) || (state_n == ST_HOLD);
      if (state == ST_REQ && state_n == ST_SETUP) d_out <= head;
    end
  end

`ifdef USB_TX_SI_EN
  localparam int unsigned IW = $clog2(SI_IDLE + 1);

  logic          push;
  logic [IW-1:0] idle_cnt;
  logic [CW-1:0] si_cnt;
  logic          si_q;
  logic          dirty;

  assign push = tx_valid && tx_ready;

  // Leaving IDLE or any push aborts both the idle count and a pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      si_cnt   <= '0;
      si_q     <= 1'b1;
      dirty    <= 1'b0;
    end else begin
      if (pop) dirty <= 1'b1;
      if (push || state != ST_IDLE || !fifo_empty) begin
        idle_cnt <= '0;
        si_cnt   <= '0;
        si_q     <= 1'b1;
      end else begin
        if (idle_cnt != IW'(SI_IDLE)) idle_cnt <= idle_cnt + IW'(1);
        if (idle_cnt == IW'(SI_IDLE - 1) && dirty) begin
          si_q   <= 1'b0;
          si_cnt <= CW'(WR_HI - 1);
          dirty  <= 1'b0;
        end else if (!si_q) begin
          if (si_cnt == '0) si_q   <= 1'b1;
          else              si_cnt <= si_cnt - CW'(1);
        end
      end
    end
  end

  assign SI = si_q;
`else
  assign SI = 1'b1;
`endif

endmodule

// File: tb/tb_usb_tx.sv
// Directed self-checking bench for usb_tx at default timing parameters.
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txe;
  logic       bus_req;
  logic       bus_gnt;
  logic       wr;
  logic [7:0] d_out;
  logic       d_oe;
  logic       SI;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned si_low_total = 0;

  int         first_wr, wr_n, oe_n, dout_n, req_n, tail_n, rdy_n;
  int         got_n, rise_n, bnd, lows, falls, first_low;
  int         rise_k [16];
  logic [7:0] bytes [17];
  logic       prev_wr, prev_si, injected;

  always #5 clk = ~clk;

  usb_tx #(
    .DEPTH    (16),
    .WR_HI    (5),
    .HOLD     (2),
    .TXE_WAIT (8),
    .SI_IDLE  (1000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txe      (txe),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .wr       (wr),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .SI       (SI)
  );

  always @(negedge clk) if (rst_n && !SI) si_low_total++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fifo_cnt();
    logic [4:0] c;
    c = dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;
    return {27'b0, c};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; txe = 1'b0; bus_gnt = 1'b1;
    repeat (3) step();
    check_val("rst_wr", wr, 0);
    check_val("rst_oe", d_oe, 0);
    check_val("rst_dout", d_out, 0);
    check_val("rst_req", bus_req, 0);
    check_val("rst_si", SI, 1);
    check_val("rst_rdy", tx_ready, 1);
    rst_n = 1'b1;
    repeat (4) step();

    // single byte: latency, strobe width, data hold
    tx_data = 8'hA5; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    first_wr = -1; wr_n = 0; oe_n = 0; dout_n = 0; req_n = 0; tail_n = 0; rdy_n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (wr) begin if (first_wr < 0) first_wr = k; wr_n++; end
      if (d_oe) oe_n++;
      if (d_oe && d_out == 8'hA5) dout_n++;
      if (bus_req) req_n++;
      if (d_oe && !wr && wr_n > 0) tail_n++;
      if (tx_ready) rdy_n++;
    end
    check_val("one_latency", first_wr, 2);
    check_val("one_wr_hi", wr_n, 5);
    check_val("one_oe", oe_n, 7);
    check_val("one_dout", dout_n, 7);
    check_val("one_req", req_n, 8);
    check_val("one_hold", tail_n, 2);
    check_val("one_rdy", rdy_n, 30);
    step();

    // fill with txe high, then drain
    txe = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_val("fill_rdy15", tx_ready, 1);
      tx_data = 8'(i); tx_valid = 1'b1; step();
    end
    tx_valid = 1'b0;
    check_val("full_rdy", tx_ready, 0);
    check_val("full_cnt", fifo_cnt(), 16);
    check_val("full_req", bus_req, 1);
    check_val("full_wr", wr, 0);
    tx_data = 8'h55; tx_valid = 1'b1; repeat (3) step(); tx_valid = 1'b0;
    check_val("refuse_rdy", tx_ready, 0);
    check_val("refuse_cnt", fifo_cnt(), 16);
    txe = 1'b0;
    got_n = 0; rise_n = 0; prev_wr = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (wr && !prev_wr && rise_n < 16) begin rise_k[rise_n] = k; rise_n++; end
      if (!wr && prev_wr) begin if (got_n < 17) bytes[got_n] = d_out; got_n++; end
      prev_wr = wr;
    end
    check_val("drain_n", got_n, 16);
    for (int i = 0; i < 16; i++) check_val($sformatf("drain_b%0d", i), bytes[i], 8'(i));
    for (int i = 1; i < 16; i++)
      check_val($sformatf("drain_gap%0d", i), rise_k[i] - rise_k[i-1], 17);
    check_val("drain_rdy", tx_ready, 1);
    step();

    // grant held off, then given and withdrawn mid-write
    bus_gnt = 1'b0;
    tx_data = 8'h3C; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    wr_n = 0; req_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr) wr_n++;
      if (bus_req) req_n++;
    end
    check_val("nogrant_wr", wr_n, 0);
    check_val("nogrant_req", req_n, 9);
    bus_gnt = 1'b1;
    @(negedge clk);
    check_val("grant_wr", wr, 1);
    check_val("grant_dout", d_out, 8'h3C);
    bus_gnt = 1'b0;
    wr_n = 1; oe_n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wr) wr_n++;
      if (d_oe) oe_n++;
    end
    check_val("withdraw_wr", wr_n, 5);
    check_val("withdraw_oe", oe_n, 7);
    bus_gnt = 1'b1;
    repeat (10) step();

    // reset during SETUP
    tx_valid = 1'b1; tx_data = 8'h77; step(); tx_data = 8'h78; step(); tx_valid = 1'b0;
    bnd = 0;
    while (!wr && bnd < 20) begin @(negedge clk); bnd++; end
    check_val("rstw_reach", wr, 1);
    rst_n = 1'b0;
    #1;
    check_val("rstw_wr", wr, 0);
    check_val("rstw_oe", d_oe, 0);
    check_val("rstw_req", bus_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rstw_rdy", tx_ready, 1);
    check_val("rstw_cnt", fifo_cnt(), 0);
    wr_n = 0; oe_n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (wr) wr_n++;
      if (d_oe) oe_n++;
    end
    check_val("rstw_nowr", wr_n, 0);
    check_val("rstw_nooe", oe_n, 0);
    step();

    // push coinciding with pop at count 8
    txe = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'h80 + 8'(i); tx_valid = 1'b1; step();
    end
    tx_valid = 1'b0;
    check_val("pp_cnt8", fifo_cnt(), 8);
    txe = 1'b0;
    got_n = 0; prev_wr = 1'b0; injected = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!wr && prev_wr) begin
        if (got_n < 17) bytes[got_n] = d_out;
        got_n++;
        if (!injected) begin
          injected = 1'b1;
          check_val("pp_pre", fifo_cnt(), 8);
          tx_data = 8'h88; tx_valid = 1'b1;
          @(posedge clk);
          #1;
          tx_valid = 1'b0;
          check_val("pp_post", fifo_cnt(), 8);
        end
      end
      prev_wr = wr;
    end
    check_val("pp_n", got_n, 9);
    for (int i = 0; i < 9; i++) check_val($sformatf("pp_b%0d", i), bytes[i], 8'h80 + 8'(i));
    step();

`ifdef USB_TX_SI_EN
    tx_data = 8'h99; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    lows = 0; falls = 0; first_low = -1; prev_si = 1'b1;
    for (int k = 0; k < 1400; k++) begin
      @(negedge clk);
      if (!SI) begin
        lows++;
        if (first_low < 0) first_low = k;
        if (wr || d_oe || bus_req) check_val("si_outside_idle", 1, 0);
      end
      if (!SI && prev_si) falls++;
      prev_si = SI;
    end
    check_val("si_first", first_low, 1017);
    check_val("si_lows", lows, 5);
    check_val("si_falls", falls, 1);
    lows = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (!SI) lows++;
    end
    check_val("si_once", lows, 0);
`else
    check_val("si_tied", si_low_total, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
